tlm_fifo: RTL and testbench

TLM_FIFO -- requirements
Module: tlm_fifo

---
 rtl/tlm_fifo.sv | 92 +++++++++
 tb/tb_tlm_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tlm_fifo.sv
// tlm_fifo: show-ahead synchronous FIFO with valid/ready put and get ports.
// Occupancy flags are registered; get_data is muxed from storage at the head.
module tlm_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           put_valid,
  output logic                           put_ready,
  input  logic [WIDTH-1:0]               put_data,
  output logic                           get_valid,
  input  logic                           get_ready,
  output logic [WIDTH-1:0]               get_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          put_fire;
  logic          get_fire;

  // Handshakes and next-state for pointers and occupancy.
  always_comb begin
    put_fire = 1'b0;
    get_fire = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    put_fire = put_valid && !full_q;
    get_fire = get_ready && !empty_q;

    if (put_fire) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (get_fire) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end

    case ({put_fire, get_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control state register; reset wins over any same-cycle handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage write; contents are left stale on reset and masked by empty.
  always_ff @(posedge clk) begin
    if (put_fire && !reset) begin
      mem_q[wr_ptr_q] <= put_data;
    end
  end

  assign put_ready = !full_q;
  assign get_valid = !empty_q;
  assign get_data  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_tlm_fifo.sv
// Directed and randomized checks for tlm_fifo (WIDTH=65, DEPTH=4).
module tb_tlm_fifo;

  localparam int unsigned WIDTH = 65;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             put_valid;
  logic             put_ready;
  logic [WIDTH-1:0] put_data;
  logic             get_valid;
  logic             get_ready;
  logic [WIDTH-1:0] get_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q [$];

  tlm_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .put_valid (put_valid),
    .put_ready (put_ready),
    .put_data  (put_data),
    .get_valid (get_valid),
    .get_ready (get_ready),
    .get_data  (get_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then stable until the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    put_valid = 1'b0;
    put_data  = '0;
    get_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset then idle
    chk("rst_count",     WIDTH'(count), WIDTH'(0));
    chk("rst_empty",     WIDTH'(empty), WIDTH'(1));
    chk("rst_full",      WIDTH'(full), WIDTH'(0));
    chk("rst_put_ready", WIDTH'(put_ready), WIDTH'(1));
    chk("rst_get_valid", WIDTH'(get_valid), WIDTH'(0));
    chk("rst_get_data",  get_data, WIDTH'(0));

    // get_ready while empty is ignored
    get_ready = 1'b1;
    step();
    get_ready = 1'b0;
    chk("empty_get_count", WIDTH'(count), WIDTH'(0));
    chk("empty_get_empty", WIDTH'(empty), WIDTH'(1));

    // Fill to full, overflow attempt, drain in order
    for (int i = 1; i <= 4; i++) begin
      put_valid = 1'b1;
      put_data  = WIDTH'(i);
      step();
    end
    chk("fill_full",      WIDTH'(full), WIDTH'(1));
    chk("fill_count",     WIDTH'(count), WIDTH'(4));
    chk("fill_put_ready", WIDTH'(put_ready), WIDTH'(0));
    put_data = WIDTH'(5);
    step();
    put_valid = 1'b0;
    chk("ovf_count", WIDTH'(count), WIDTH'(4));
    chk("ovf_head",  get_data, WIDTH'(1));
    get_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", WIDTH'(get_valid), WIDTH'(1));
      chk("drain_data",  get_data, WIDTH'(i));
      step();
    end
    get_ready = 1'b0;
    chk("drain_empty", WIDTH'(empty), WIDTH'(1));
    chk("drain_count", WIDTH'(count), WIDTH'(0));
    chk("drain_data0", get_data, WIDTH'(0));

    // One-cycle latency from put to get_valid
    put_valid = 1'b1;
    put_data  = WIDTH'(65'h1ABCD);
    #1;
    chk("lat_same_cycle_valid", WIDTH'(get_valid), WIDTH'(0));
    chk("lat_same_cycle_data",  get_data, WIDTH'(0));
    step();
    put_valid = 1'b0;
    chk("lat_next_valid", WIDTH'(get_valid), WIDTH'(1));
    chk("lat_next_data",  get_data, WIDTH'(65'h1ABCD));
    get_ready = 1'b1;
    step();
    get_ready = 1'b0;
    chk("lat_drain_empty", WIDTH'(empty), WIDTH'(1));

    // Streaming at count=1 with simultaneous put and get
    put_valid = 1'b1;
    put_data  = WIDTH'(100);
    step();
    get_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      put_data = WIDTH'(101 + k);
      chk("stream_data", get_data, WIDTH'(100 + k));
      step();
      chk("stream_count", WIDTH'(count), WIDTH'(1));
      chk("stream_valid", WIDTH'(get_valid), WIDTH'(1));
    end
    put_valid = 1'b0;
    chk("stream_last", get_data, WIDTH'(120));
    step();
    get_ready = 1'b0;
    chk("stream_empty", WIDTH'(empty), WIDTH'(1));

    // Mid-stream reset with a concurrent put
    put_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put_data = WIDTH'(8'h11 + i);
      step();
    end
    chk("pre_rst_count", WIDTH'(count), WIDTH'(3));
    reset    = 1'b1;
    put_data = WIDTH'(8'h99);
    step();
    reset     = 1'b0;
    put_valid = 1'b0;
    chk("midrst_count", WIDTH'(count), WIDTH'(0));
    chk("midrst_valid", WIDTH'(get_valid), WIDTH'(0));
    chk("midrst_data",  get_data, WIDTH'(0));
    put_valid = 1'b1;
    put_data  = WIDTH'(7);
    step();
    put_data = WIDTH'(8);
    step();
    put_valid = 1'b0;
    chk("post_rst_count", WIDTH'(count), WIDTH'(2));
    chk("post_rst_head",  get_data, WIDTH'(7));
    get_ready = 1'b1;
    step();
    chk("post_rst_second", get_data, WIDTH'(8));
    step();
    get_ready = 1'b0;
    chk("post_rst_empty", WIDTH'(empty), WIDTH'(1));

    // Random traffic against a queue model
    model_q.delete();
    for (int c = 0; c < 10000 && errors < 50; c++) begin
      bit pv;
      bit gr;
      bit do_put;
      bit do_get;
      pv = 1'($urandom_range(0, 1));
      gr = 1'($urandom_range(0, 1));
      put_valid = pv;
      get_ready = gr;
      put_data  = WIDTH'({$urandom, $urandom, $urandom});
      #1;
      chk("rnd_count",     WIDTH'(count), WIDTH'(model_q.size()));
      chk("rnd_full",      WIDTH'(full), WIDTH'(model_q.size() == DEPTH));
      chk("rnd_get_valid", WIDTH'(get_valid), WIDTH'(model_q.size() != 0));
      chk("rnd_put_ready", WIDTH'(put_ready), WIDTH'(model_q.size() != DEPTH));
      chk("rnd_get_data",  get_data, (model_q.size() != 0) ? model_q[0] : WIDTH'(0));
      do_put = pv && (model_q.size() < DEPTH);
      do_get = gr && (model_q.size() > 0);
      if (do_get) void'(model_q.pop_front());
      if (do_put) model_q.push_back(put_data);
      step();
    end
    put_valid = 1'b0;
    get_ready = 1'b0;
    #1;
    chk("rnd_final_count", WIDTH'(count), WIDTH'(model_q.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
